rob_multiport: RTL and testbench

//  Parametrised reorder buffer: circular queue of DEPTH entries between rename/dispatch and the arch regfile.

---
 rtl/rob_multiport.sv | 232 +++++++++++++++++++++++
 tb/tb_rob_multiport.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multiport.sv
// ---------------------------------------------------------------------------
// rob_multiport
//
// Reorder buffer: a circular queue of DEPTH entries between rename/dispatch
// and the architectural register file. One instruction is allocated per
// cycle in program order. NUM_WB writeback ports mark entries complete in
// any order. Completed entries retire strictly in order, at most one per
// cycle, on registered commit outputs. A synchronous flush discards every
// in-flight entry.
//
// Optional feature macro: ROB_EXC_EN
//   When defined, each writeback port carries an exception flag (wb_exc_i).
//   Retiring an excepting entry pulses commit_exc_o together with
//   commit_valid_o, and the buffer empties itself at that same edge.
//
// Ports
//   clk_i               clock, rising edge
//   reset_i             synchronous reset, active low
//   flush_i             discard every entry
//   alloc_req_i         allocate one entry this cycle
//   prd_addr_i          destination register of the allocated instruction
//   pc_i / inst_i       pc / encoding of the allocated instruction
//   alloc_ready_o       not full
//   rob_idx_o           index granted to this cycle's allocation (tail)
//   wb_valid_i          per-port writeback strobe
//   wb_idx_i            packed target indices, port p at [p*IDX_W +: IDX_W]
//   wb_value_i          packed result values, port p at [p*XLEN +: XLEN]
//   wb_exc_i            per-port exception flag (ROB_EXC_EN only)
//   empty_o / full_o    occupancy is zero / DEPTH
//   count_o             occupied entries
//   commit_valid_o      one-cycle pulse per retired entry
//   commit_idx_o        index of the retired entry
//   commit_pc_o         pc of the retired entry
//   commit_inst_o       encoding of the retired entry
//   commit_prd_addr_o   destination register of the retired entry
//   commit_exc_o        retired entry raised an exception (ROB_EXC_EN only)
//   commit_prd_value_o  result of the retired entry
// ---------------------------------------------------------------------------
module rob_multiport #(
    parameter  int DEPTH  = 16,
    parameter  int NUM_WB = 3,
    parameter  int XLEN   = 32,
    parameter  int PRD_W  = 5,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    flush_i,

    input  logic                    alloc_req_i,
    input  logic [PRD_W-1:0]        prd_addr_i,
    input  logic [XLEN-1:0]         pc_i,
    input  logic [XLEN-1:0]         inst_i,
    output logic                    alloc_ready_o,
    output logic [IDX_W-1:0]        rob_idx_o,

    input  logic [NUM_WB-1:0]       wb_valid_i,
    input  logic [NUM_WB*IDX_W-1:0] wb_idx_i,
    input  logic [NUM_WB*XLEN-1:0]  wb_value_i,
`ifdef ROB_EXC_EN
    input  logic [NUM_WB-1:0]       wb_exc_i,
`endif

    output logic                    empty_o,
    output logic                    full_o,
    output logic [IDX_W:0]          count_o,

    output logic                    commit_valid_o,
    output logic [IDX_W-1:0]        commit_idx_o,
    output logic [XLEN-1:0]         commit_pc_o,
    output logic [XLEN-1:0]         commit_inst_o,
    output logic [PRD_W-1:0]        commit_prd_addr_o,
`ifdef ROB_EXC_EN
    output logic                    commit_exc_o,
`endif
    output logic [XLEN-1:0]         commit_prd_value_o
);

    localparam logic [IDX_W:0] PTR_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(DEPTH);

    // Pointers carry an extra wrap bit; only the low IDX_W bits address entries.
    logic [IDX_W:0]   head_q;
    logic [IDX_W:0]   tail_q;
    logic [IDX_W:0]   count_q;
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] done_q;

    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [XLEN-1:0]  inst_q  [DEPTH];
    logic [XLEN-1:0]  value_q [DEPTH];
    logic [PRD_W-1:0] prd_q   [DEPTH];
`ifdef ROB_EXC_EN
    logic [DEPTH-1:0] exc_q;
`endif

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             full;
    logic             alloc_fire;
    logic             commit_fire;
    logic             self_flush;

    logic [IDX_W-1:0] wb_idx [NUM_WB];
    logic [XLEN-1:0]  wb_val [NUM_WB];
    logic [NUM_WB-1:0] wb_hit;

    assign head_idx    = head_q[IDX_W-1:0];
    assign tail_idx    = tail_q[IDX_W-1:0];
    assign full        = (count_q == CNT_FULL);
    assign alloc_fire  = alloc_req_i && !full;
    assign commit_fire = valid_q[head_idx] && done_q[head_idx];

`ifdef ROB_EXC_EN
    assign self_flush  = commit_fire && exc_q[head_idx];
`else
    assign self_flush  = 1'b0;
`endif

    assign alloc_ready_o = !full;
    assign full_o        = full;
    assign empty_o       = (count_q == '0);
    assign count_o       = count_q;
    assign rob_idx_o     = tail_idx;

    // A writeback only lands on an entry that is already valid, so the slot
    // being allocated this cycle (invalid until the edge) can never be hit.
    always_comb begin
        for (int p = 0; p < NUM_WB; p++) begin
            wb_idx[p] = wb_idx_i[p*IDX_W +: IDX_W];
            wb_val[p] = wb_value_i[p*XLEN +: XLEN];
            wb_hit[p] = wb_valid_i[p] && valid_q[wb_idx[p]];
        end
    end

    // Control state and commit outputs.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            head_q             <= '0;
            tail_q             <= '0;
            count_q            <= '0;
            valid_q            <= '0;
            done_q             <= '0;
            commit_valid_o     <= 1'b0;
            commit_idx_o       <= '0;
            commit_pc_o        <= '0;
            commit_inst_o      <= '0;
            commit_prd_addr_o  <= '0;
            commit_prd_value_o <= '0;
`ifdef ROB_EXC_EN
            commit_exc_o       <= 1'b0;
`endif
        end else if (flush_i) begin
            // Commit data fields deliberately hold across a flush.
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            valid_q        <= '0;
            done_q         <= '0;
            commit_valid_o <= 1'b0;
`ifdef ROB_EXC_EN
            commit_exc_o   <= 1'b0;
`endif
        end else begin
            commit_valid_o <= commit_fire;
`ifdef ROB_EXC_EN
            commit_exc_o   <= self_flush;
`endif
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_hit[p]) begin
                    done_q[wb_idx[p]] <= 1'b1;
                end
            end

            if (alloc_fire) begin
                valid_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
                tail_q            <= tail_q + PTR_ONE;
            end

            // Placed after the writeback loop so a late writeback to the
            // retiring head cannot resurrect it.
            if (commit_fire) begin
                valid_q[head_idx]  <= 1'b0;
                done_q[head_idx]   <= 1'b0;
                head_q             <= head_q + PTR_ONE;
                commit_idx_o       <= head_idx;
                commit_pc_o        <= pc_q[head_idx];
                commit_inst_o      <= inst_q[head_idx];
                commit_prd_addr_o  <= prd_q[head_idx];
                commit_prd_value_o <= value_q[head_idx];
            end

            case ({alloc_fire, commit_fire})
                2'b10:   count_q <= count_q + PTR_ONE;
                2'b01:   count_q <= count_q - PTR_ONE;
                default: count_q <= count_q;
            endcase

            // Excepting retire: everything younger is squashed at the same edge.
            if (self_flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                valid_q <= '0;
                done_q  <= '0;
            end
        end
    end

    // Payload storage. Contents are only observed through valid/done, so
    // these arrays need no reset.
    always_ff @(posedge clk_i) begin
        if (reset_i && !flush_i) begin
            // Later ports overwrite earlier ones: highest-numbered port wins.
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_hit[p]) begin
                    value_q[wb_idx[p]] <= wb_val[p];
`ifdef ROB_EXC_EN
                    exc_q[wb_idx[p]]   <= wb_exc_i[p];
`endif
                end
            end
            if (alloc_fire) begin
                pc_q[tail_idx]   <= pc_i;
                inst_q[tail_idx] <= inst_i;
                prd_q[tail_idx]  <= prd_addr_i;
            end
        end
    end

endmodule

// File: tb/tb_rob_multiport.sv
module tb_rob_multiport;

    localparam int DEPTH  = 16;
    localparam int NUM_WB = 3;
    localparam int XLEN   = 32;
    localparam int PRD_W  = 5;
    localparam int IDX_W  = 4;

    logic                    clk_i;
    logic                    reset_i;
    logic                    flush_i;
    logic                    alloc_req_i;
    logic [PRD_W-1:0]        prd_addr_i;
    logic [XLEN-1:0]         pc_i;
    logic [XLEN-1:0]         inst_i;
    logic                    alloc_ready_o;
    logic [IDX_W-1:0]        rob_idx_o;
    logic [NUM_WB-1:0]       wb_valid_i;
    logic [NUM_WB*IDX_W-1:0] wb_idx_i;
    logic [NUM_WB*XLEN-1:0]  wb_value_i;
    logic                    empty_o;
    logic                    full_o;
    logic [IDX_W:0]          count_o;
    logic                    commit_valid_o;
    logic [IDX_W-1:0]        commit_idx_o;
    logic [XLEN-1:0]         commit_pc_o;
    logic [XLEN-1:0]         commit_inst_o;
    logic [PRD_W-1:0]        commit_prd_addr_o;
    logic [XLEN-1:0]         commit_prd_value_o;
`ifdef ROB_EXC_EN
    logic [NUM_WB-1:0]       wb_exc_i;
    logic                    commit_exc_o;
`endif

    rob_multiport #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .XLEN(XLEN), .PRD_W(PRD_W)) dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .flush_i            (flush_i),
        .alloc_req_i        (alloc_req_i),
        .prd_addr_i         (prd_addr_i),
        .pc_i               (pc_i),
        .inst_i             (inst_i),
        .alloc_ready_o      (alloc_ready_o),
        .rob_idx_o          (rob_idx_o),
        .wb_valid_i         (wb_valid_i),
        .wb_idx_i           (wb_idx_i),
        .wb_value_i         (wb_value_i),
`ifdef ROB_EXC_EN
        .wb_exc_i           (wb_exc_i),
`endif
        .empty_o            (empty_o),
        .full_o             (full_o),
        .count_o            (count_o),
        .commit_valid_o     (commit_valid_o),
        .commit_idx_o       (commit_idx_o),
        .commit_pc_o        (commit_pc_o),
        .commit_inst_o      (commit_inst_o),
        .commit_prd_addr_o  (commit_prd_addr_o),
`ifdef ROB_EXC_EN
        .commit_exc_o       (commit_exc_o),
`endif
        .commit_prd_value_o (commit_prd_value_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight instructions kept in program order.
    typedef struct {
        int               idx;
        logic [PRD_W-1:0] prd;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  inst;
        logic [XLEN-1:0]  val;
        bit               done;
        bit               exc;
    } ent_t;

    ent_t             mq[$];
    int               m_tail;
    bit               e_cv;
    bit               e_cexc;
    logic [IDX_W-1:0] e_cidx;
    logic [XLEN-1:0]  e_cpc;
    logic [XLEN-1:0]  e_cinst;
    logic [PRD_W-1:0] e_cprd;
    logic [XLEN-1:0]  e_cval;

    task automatic model_edge();
        ent_t h;
        ent_t n;
        bit   com;
        bit   is_full;
        int   widx;
        if (!reset_i) begin
            mq.delete();
            m_tail = 0;
            e_cv = 0; e_cexc = 0; e_cidx = '0; e_cpc = '0;
            e_cinst = '0; e_cprd = '0; e_cval = '0;
            return;
        end
        if (flush_i) begin
            mq.delete();
            m_tail = 0;
            e_cv = 0;
            e_cexc = 0;
            return;
        end
        is_full = (mq.size() == DEPTH);
        com = (mq.size() > 0) && mq[0].done;
        if (com) h = mq[0];
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid_i[p]) begin
                widx = int'(wb_idx_i[p*IDX_W +: IDX_W]);
                foreach (mq[i]) begin
                    if (mq[i].idx == widx) begin
                        mq[i].done = 1;
                        mq[i].val  = wb_value_i[p*XLEN +: XLEN];
`ifdef ROB_EXC_EN
                        mq[i].exc  = wb_exc_i[p];
`endif
                    end
                end
            end
        end
        if (com) void'(mq.pop_front());
        if (alloc_req_i && !is_full) begin
            n.idx = m_tail; n.prd = prd_addr_i; n.pc = pc_i; n.inst = inst_i;
            n.val = '0; n.done = 0; n.exc = 0;
            mq.push_back(n);
            m_tail = (m_tail + 1) % DEPTH;
        end
        e_cv = com;
        e_cexc = 0;
        if (com) begin
            e_cidx = h.idx[IDX_W-1:0];
            e_cpc = h.pc; e_cinst = h.inst; e_cprd = h.prd; e_cval = h.val;
            if (h.exc) begin
                e_cexc = 1;
                mq.delete();
                m_tail = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [IDX_W:0] mc;
        mc = (IDX_W+1)'(mq.size());
        chk("commit", {commit_valid_o, commit_idx_o, commit_pc_o, commit_inst_o, commit_prd_addr_o, commit_prd_value_o},
                      {e_cv, e_cidx, e_cpc, e_cinst, e_cprd, e_cval});
        chk("status", {count_o, empty_o, full_o, alloc_ready_o, rob_idx_o},
                      {mc, mq.size() == 0, mq.size() == DEPTH, mq.size() != DEPTH, 4'(m_tail)});
`ifdef ROB_EXC_EN
        chk("commit_exc", commit_exc_o, e_cexc);
`endif
    endtask

    task automatic step();
        model_edge();
        @(posedge clk_i);
        #1;
        check_all();
    endtask

    task automatic set_idle();
        flush_i = 0; alloc_req_i = 0; prd_addr_i = '0; pc_i = '0; inst_i = '0;
        wb_valid_i = '0; wb_idx_i = '0; wb_value_i = '0;
`ifdef ROB_EXC_EN
        wb_exc_i = '0;
`endif
    endtask

    task automatic set_wb(input int p, input int idx, input logic [XLEN-1:0] v);
        wb_valid_i[p] = 1'b1;
        wb_idx_i[p*IDX_W +: IDX_W] = idx[IDX_W-1:0];
        wb_value_i[p*XLEN +: XLEN] = v;
    endtask

    task automatic do_alloc(input logic [PRD_W-1:0] prd, input logic [XLEN-1:0] pc);
        set_idle();
        alloc_req_i = 1; prd_addr_i = prd; pc_i = pc; inst_i = pc ^ 32'h1357_0000;
        step();
    endtask

    task automatic do_reset();
        set_idle();
        reset_i = 0;
        step();
        step();
        reset_i = 1;
    endtask

    typedef struct {
        bit               alloc;
        logic [PRD_W-1:0] prd;
        logic [XLEN-1:0]  pc;
        logic [2:0]       wbv;
        logic [11:0]      wbidx;
        logic [95:0]      wbval;
        bit               e_cv;
        logic [IDX_W-1:0] e_idx;
        logic [PRD_W-1:0] e_prd;
        logic [XLEN-1:0]  e_val;
        logic [IDX_W:0]   e_cnt;
        bit               e_empty;
    } vec_t;

    vec_t tv[7];

    initial begin
        bit               seen;
        logic [XLEN-1:0]  got;
        int               pick;

        // Two allocations, out-of-order completion, in-order retirement.
        tv[0] = '{1'b1, 5'd5, 32'h0, 3'b000, 12'h000, 96'h0,                 1'b0, 4'd0, 5'd0, 32'h0, 5'd1, 1'b0};
        tv[1] = '{1'b1, 5'd3, 32'h4, 3'b000, 12'h000, 96'h0,                 1'b0, 4'd0, 5'd0, 32'h0, 5'd2, 1'b0};
        tv[2] = '{1'b0, 5'd0, 32'h0, 3'b010, 12'h010, {32'h0, 32'h5, 32'h0}, 1'b0, 4'd0, 5'd0, 32'h0, 5'd2, 1'b0};
        tv[3] = '{1'b0, 5'd0, 32'h0, 3'b001, 12'h000, {64'h0, 32'hA},        1'b0, 4'd0, 5'd0, 32'h0, 5'd2, 1'b0};
        tv[4] = '{1'b0, 5'd0, 32'h0, 3'b000, 12'h000, 96'h0,                 1'b1, 4'd0, 5'd5, 32'hA, 5'd1, 1'b0};
        tv[5] = '{1'b0, 5'd0, 32'h0, 3'b000, 12'h000, 96'h0,                 1'b1, 4'd1, 5'd3, 32'h5, 5'd0, 1'b1};
        tv[6] = '{1'b0, 5'd0, 32'h0, 3'b000, 12'h000, 96'h0,                 1'b0, 4'd0, 5'd0, 32'h0, 5'd0, 1'b1};

        reset_i = 0;
        do_reset();
        chk("reset_state", {empty_o, full_o, count_o, commit_valid_o, rob_idx_o}, {1'b1, 1'b0, 5'd0, 1'b0, 4'd0});

        for (int i = 0; i < 7; i++) begin
            set_idle();
            alloc_req_i = tv[i].alloc; prd_addr_i = tv[i].prd; pc_i = tv[i].pc; inst_i = tv[i].pc ^ 32'h1357_0000;
            wb_valid_i = tv[i].wbv; wb_idx_i = tv[i].wbidx; wb_value_i = tv[i].wbval;
            step();
            chk($sformatf("vec%0d_state", i), {commit_valid_o, count_o, empty_o}, {tv[i].e_cv, tv[i].e_cnt, tv[i].e_empty});
            if (tv[i].e_cv)
                chk($sformatf("vec%0d_commit", i), {commit_idx_o, commit_prd_addr_o, commit_prd_value_o},
                    {tv[i].e_idx, tv[i].e_prd, tv[i].e_val});
        end

        // Fill to full, reject the 17th, retire idx0 under a rejected alloc, wrap.
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_alloc(5'(i), 32'(i * 4));
        chk("fill_full", {full_o, alloc_ready_o, count_o}, {1'b1, 1'b0, 5'd16});
        do_alloc(5'd31, 32'hFFFF_0000);
        chk("overflow_ignored", {count_o, rob_idx_o}, {5'd16, 4'd0});
        set_idle(); alloc_req_i = 1; set_wb(0, 0, 32'h77);
        step();
        chk("full_wb", {commit_valid_o, count_o}, {1'b0, 5'd16});
        set_idle(); alloc_req_i = 1;
        step();
        chk("full_commit", {commit_valid_o, commit_idx_o, commit_prd_value_o, count_o, rob_idx_o},
            {1'b1, 4'd0, 32'h77, 5'd15, 4'd0});
        do_alloc(5'd9, 32'h100);
        chk("wrap_alloc", {count_o, full_o, rob_idx_o}, {5'd16, 1'b1, 4'd1});

        // Same-index writeback priority and writeback to an unallocated slot.
        do_reset();
        for (int i = 0; i < 5; i++) do_alloc(5'(i + 1), 32'(i * 4));
        set_idle(); set_wb(0, 4, 32'h11); set_wb(2, 4, 32'h22); set_wb(1, 9, 32'h99);
        step();
        set_idle(); set_wb(0, 0, 32'h1); set_wb(1, 1, 32'h2); set_wb(2, 2, 32'h3);
        step();
        set_idle(); set_wb(0, 3, 32'h4);
        step();
        seen = 0; got = '0;
        for (int k = 0; k < 8; k++) begin
            set_idle();
            step();
            if (commit_valid_o && commit_idx_o == 4'd4) begin
                seen = 1;
                got = commit_prd_value_o;
            end
        end
        chk("wb_priority", {seen, got}, {1'b1, 32'h22});
        chk("drained", {empty_o, count_o}, {1'b1, 5'd0});
        for (int i = 0; i < 5; i++) do_alloc(5'(i), 32'(i));
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            set_idle();
            step();
            if (commit_valid_o) seen = 1;
        end
        chk("wb_unallocated", {seen, count_o}, {1'b0, 5'd5});

        // Flush overrides allocate, writeback and a pending commit.
        do_reset();
        for (int i = 0; i < 6; i++) do_alloc(5'(i), 32'(i * 8));
        set_idle(); set_wb(0, 0, 32'hA0); set_wb(1, 1, 32'hA1); set_wb(2, 2, 32'hA2);
        step();
        set_idle(); flush_i = 1; alloc_req_i = 1; set_wb(0, 3, 32'hA3);
        step();
        chk("flush", {commit_valid_o, count_o, empty_o, rob_idx_o}, {1'b0, 5'd0, 1'b1, 4'd0});
        do_alloc(5'd7, 32'h200);
        chk("post_flush_alloc", {count_o, rob_idx_o}, {5'd1, 4'd1});

`ifdef ROB_EXC_EN
        do_reset();
        for (int i = 0; i < 3; i++) do_alloc(5'(i), 32'(i * 4));
        set_idle(); set_wb(0, 0, 32'hE0); wb_exc_i[0] = 1'b1; set_wb(1, 1, 32'hE1);
        step();
        set_idle();
        step();
        chk("exc_commit", {commit_valid_o, commit_exc_o, commit_idx_o, empty_o, count_o},
            {1'b1, 1'b1, 4'd0, 1'b1, 5'd0});
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            set_idle();
            step();
            if (commit_valid_o) seen = 1;
        end
        chk("exc_squash", seen, 1'b0);
`endif

        // Randomised traffic against the model.
        do_reset();
        for (int c = 0; c < 1200; c++) begin
            set_idle();
            alloc_req_i = ($urandom % 10) < 6;
            prd_addr_i  = 5'($urandom);
            pc_i        = $urandom;
            inst_i      = $urandom;
            for (int p = 0; p < NUM_WB; p++) begin
                if (($urandom % (((c / 150) % 2 == 0) ? 2 : 8)) == 0) begin
                    if (mq.size() > 0 && ($urandom % 4) != 0) begin
                        pick = int'($urandom % mq.size());
                        set_wb(p, mq[pick].idx, $urandom);
                    end else begin
                        set_wb(p, int'($urandom % DEPTH), $urandom);
                    end
`ifdef ROB_EXC_EN
                    wb_exc_i[p] = ($urandom % 16) == 0;
`endif
                end
            end
            flush_i = ($urandom % 60) == 0;
            reset_i = ($urandom % 150) != 0;
            step();
        end
        reset_i = 1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
